// File: rtl/grid_pkg.sv
// Shared grid geometry, byte-bus width and serializer state encoding.
package grid_pkg;
  localparam int GRID_W    = 16;
  localparam int GRID_H    = 16;
  localparam int GRID_BITS = GRID_W * GRID_H;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = GRID_BITS / BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;
endpackage

// File: rtl/edge_sync_rise.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A raw rise on din produces a one-cycle rise pulse after the third clock edge.
module edge_sync_rise (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic rise
);
  logic sync1, sync2, dly;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      dly   <= sync2;
      rise  <= sync2 & ~dly;
    end
  end
endmodule

// File: rtl/grid_frame_serializer.sv
// Captures a grid snapshot and streams it byte-by-byte on Arduino request edges.
// Optional watchdog: define SERIALIZER_TIMEOUT_EN to add timeout_err and TIMEOUT_CYCLES.
module grid_frame_serializer #(
  parameter int GRID_BITS = grid_pkg::GRID_BITS,
  parameter int BYTE_W    = grid_pkg::BYTE_W
`ifdef SERIALIZER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 frame_valid,
  input  logic [GRID_BITS-1:0] frame_data,
  output logic                 frame_ready,
  input  logic                 ard_clk,
  output logic                 ard_start,
  output logic [BYTE_W-1:0]    led_out,
  output logic                 busy,
  output logic                 frame_done
`ifdef SERIALIZER_TIMEOUT_EN
  , output logic               timeout_err
`endif
);
  import grid_pkg::*;

  localparam int NUM_BYTES = GRID_BITS / BYTE_W;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [GRID_BITS-1:0]   frame_q, frame_n;
  logic [BYTE_W-1:0]      led_n;
  logic                   start_n, busy_n, done_n, ready_n;
  logic                   rise;
`ifdef SERIALIZER_TIMEOUT_EN
  logic [31:0]            cnt, cnt_n;
  logic                   err_n;
`endif

  edge_sync_rise u_ard_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (ard_clk),
    .rise    (rise)
  );

  // Outputs are registered and computed one cycle ahead so that LOAD and DONE
  // present their strobes during the state itself.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    frame_n = frame_q;
    led_n   = led_out;
    start_n = ard_start;
    busy_n  = busy;
    done_n  = 1'b0;
    ready_n = 1'b0;
`ifdef SERIALIZER_TIMEOUT_EN
    cnt_n   = cnt;
    err_n   = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (frame_valid && frame_ready) begin
          state_n = LOAD;
          frame_n = frame_data;
          idx_n   = '0;
          led_n   = frame_data[BYTE_W-1:0];
          start_n = 1'b1;
          busy_n  = 1'b1;
`ifdef SERIALIZER_TIMEOUT_EN
          err_n   = 1'b0;
`endif
        end else begin
          ready_n = 1'b1;
        end
      end
      LOAD: begin
        state_n = SEND;
`ifdef SERIALIZER_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      SEND: begin
        if (rise) begin
`ifdef SERIALIZER_TIMEOUT_EN
          cnt_n = '0;
`endif
          if (idx == LAST_IDX) begin
            state_n = DONE;
            done_n  = 1'b1;
            start_n = 1'b0;
            busy_n  = 1'b0;
          end else begin
            idx_n = idx + 1'b1;
            led_n = frame_q[idx_n*BYTE_W +: BYTE_W];
          end
        end
`ifdef SERIALIZER_TIMEOUT_EN
        else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          start_n = 1'b0;
          busy_n  = 1'b0;
          err_n   = 1'b1;
          ready_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      DONE: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      frame_q     <= '0;
      led_out     <= '0;
      ard_start   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_ready <= 1'b0;
`ifdef SERIALIZER_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      frame_q     <= frame_n;
      led_out     <= led_n;
      ard_start   <= start_n;
      busy        <= busy_n;
      frame_done  <= done_n;
      frame_ready <= ready_n;
`ifdef SERIALIZER_TIMEOUT_EN
      cnt         <= cnt_n;
      timeout_err <= err_n;
`endif
    end
  end
endmodule

// File: tb/tb_grid_frame_serializer.sv
// Scoreboard bench: expected bytes are queued when a frame is offered and
// popped as the serializer presents each byte.
module tb_grid_frame_serializer;
  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         frame_valid = 1'b0;
  logic [255:0] frame_data = '0;
  logic         frame_ready;
  logic         ard_clk = 1'b0;
  logic         ard_start;
  logic [7:0]   led_out;
  logic         busy;
  logic         frame_done;
`ifdef SERIALIZER_TIMEOUT_EN
  logic         timeout_err;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  grid_frame_serializer #(
    .GRID_BITS (256),
    .BYTE_W    (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .ard_clk     (ard_clk),
    .ard_start   (ard_start),
    .led_out     (led_out),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef SERIALIZER_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_frame(input logic [7:0] base);
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 32; k++) f[k*8 +: 8] = base + 8'(k);
    return f;
  endfunction

  task automatic push_frame(input logic [255:0] d);
    for (int k = 0; k < 32; k++) exp_q.push_back(d[k*8 +: 8]);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, led_out, e);
    end
  endtask

  task automatic wait_start(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ard_start) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_accept"}, seen, 1);
  endtask

  task automatic offer(input logic [255:0] d, input string tag);
    push_frame(d);
    @(negedge clock);
    frame_data  = d;
    frame_valid = 1'b1;
    wait_start(tag);
    frame_valid = 1'b0;
    pop_chk({tag, "_byte0"});
  endtask

  task automatic pulse(input int hi, input int lo);
    @(negedge clock);
    ard_clk = 1'b1;
    repeat (hi) @(negedge clock);
    ard_clk = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic send_bytes(input int n, input int hi, input int lo, input string tag);
    for (int i = 0; i < n; i++) begin
      pulse(hi, lo);
      pop_chk(tag);
    end
  endtask

  task automatic finish_frame(input int hi, input int lo, input string tag);
    int d0;
    d0 = done_cnt;
    pulse(hi, lo);
    chk({tag, "_done_pulse"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    bit ok;
    logic [7:0] prev;

    // Reset with ard_clk held high.
    ard_clk = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ard_start", ard_start, 0);
    chk("rst_led", led_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", frame_ready, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    #1 chk("ready_before_edge", frame_ready, 0);
    @(negedge clock);
    chk("ready_after_rst", frame_ready, 1);
    repeat (6) @(negedge clock);
    chk("idle_ard_start", ard_start, 0);
    chk("idle_busy", busy, 0);
    chk("idle_led", led_out, 0);
    chk("idle_no_done", done_cnt, 0);
    chk("idle_ready", frame_ready, 1);
    ard_clk = 1'b0;
    repeat (4) @(negedge clock);

    // Frame A: byte k = k+1.
    offer(mk_frame(8'h01), "A");
    chk("A_led01", led_out, 8'h01);
    chk("A_start", ard_start, 1);
    chk("A_busy", busy, 1);
    chk("A_ready", frame_ready, 0);
    send_bytes(31, 4, 4, "A_byte");
    chk("A_led20", led_out, 8'h20);
    finish_frame(4, 4, "A");
    chk("A_start_low", ard_start, 0);
    chk("A_busy_low", busy, 0);
    chk("A_ready_back", frame_ready, 1);

    // Frame B, with frame C held on frame_valid during the transfer.
    offer(mk_frame(8'h40), "B");
    frame_data  = mk_frame(8'h80);
    frame_valid = 1'b1;
    send_bytes(15, 4, 4, "B_byte");
    chk("B_ready_mid", frame_ready, 0);
    send_bytes(16, 4, 4, "B_byte");
    push_frame(mk_frame(8'h80));
    d0 = done_cnt;
    finish_frame(4, 4, "B");
    if (!ard_start) wait_start("C");
    frame_valid = 1'b0;
    chk("C_after_B_done", done_cnt, d0 + 1);
    pop_chk("C_byte0");
    send_bytes(10, 4, 4, "C_byte");

    // Asynchronous reset mid-transfer.
    d0 = done_cnt;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_start", ard_start, 0);
    chk("midrst_led", led_out, 0);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("midrst_no_done", done_cnt, d0);

    // Frame D: narrow pulse, then 3-cycle pulses.
    offer(mk_frame(8'hC0), "D");
    chk("D_led_c0", led_out, 8'hC0);
    prev = led_out;
    pulse(1, 5);
    ok = (led_out == prev) || (exp_q.size() > 0 && led_out == exp_q[0]);
    chk("D_narrow", ok, 1);
    if (exp_q.size() > 0 && led_out == exp_q[0]) void'(exp_q.pop_front());
    send_bytes(exp_q.size(), 3, 3, "D_byte");
    finish_frame(3, 3, "D");
    chk("D_start_low", ard_start, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
